// File: rtl/sdbp_pkg.sv
// Shared defaults, state encodings and RAM geometry helpers for the
// sdbp zone sender.
package sdbp_pkg;

  localparam int DEF_NUM_ZONES = 360;
  localparam int DEF_ZONE_W    = 16;
  localparam int DEF_ADDR_W    = 10;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_FILL = 1'b1
  } cap_state_e;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_LOAD  = 3'd1,
    T_SHIFT = 3'd2,
    T_CSH   = 3'd3,
    T_LATCH = 3'd4
  } tx_state_e;

  // Two banks of one frame each.
  function automatic int ram_depth(input int num_zones);
    return 2 * num_zones;
  endfunction

  // Width of the linear address covering both banks.
  function automatic int ram_aw(input int num_zones);
    return $clog2(2 * num_zones);
  endfunction

endpackage

// File: rtl/sdbp_zone_ram.sv
// Ping-pong zone store: one write port, one registered read port.
// The {bank, idx} pair is folded into a linear address so the depth is
// exactly two frames.
module sdbp_zone_ram
  import sdbp_pkg::*;
#(
  parameter int NUM_ZONES = DEF_NUM_ZONES,
  parameter int ZONE_W    = DEF_ZONE_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              wr_bank_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  logic [ZONE_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic [ZONE_W-1:0] rd_data_o
);

  localparam int DEPTH = ram_depth(NUM_ZONES);
  localparam int AW    = ram_aw(NUM_ZONES);

  logic [ZONE_W-1:0] mem_q [0:DEPTH-1];
  logic [ZONE_W-1:0] rd_data_q;
  logic [AW-1:0]     wr_addr_s;
  logic [AW-1:0]     rd_addr_s;

  function automatic logic [AW-1:0] lin_addr(input logic bank, input logic [ADDR_W-1:0] idx);
    return AW'(idx) + (bank ? AW'(NUM_ZONES) : AW'(0));
  endfunction

  assign wr_addr_s = lin_addr(wr_bank_i, wr_idx_i);
  assign rd_addr_s = lin_addr(rd_bank_i, rd_idx_i);
  assign rd_data_o = rd_data_q;

  // Write port: contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_s] <= wr_data_i;
  end

  // Read port: data appears the cycle after rd_en_i and holds otherwise.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_s];
  end

endmodule

// File: rtl/sdbp_zone_sender.sv
// Captures one frame of zone values from the wtaddr/wtdina interface into a
// ping-pong RAM and streams the finished frame MSB-first over SPI, followed
// by a latch pulse. Capture of the next frame overlaps transmission.
module sdbp_zone_sender
  import sdbp_pkg::*;
#(
  parameter int NUM_ZONES  = DEF_NUM_ZONES,
  parameter int ZONE_W     = DEF_ZONE_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CLK_DIV    = 2,
  parameter int LAT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdbpflag,
  input  logic [ADDR_W-1:0] wtaddr,
  input  logic [ZONE_W-1:0] wtdina,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              spi_lat,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_MAX = (CLK_DIV > LAT_CYCLES) ? CLK_DIV : LAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(ZONE_W);

  // Capture side
  cap_state_e        cap_state_q, cap_state_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              sflag_q, sflag_prev_q, edge_s;
  logic              start_q, start_d;
  logic              err_q, err_d, ovr_q, ovr_d;
  logic              we_s, tx_idle_s;

  // Transmit side
  tx_state_e         tx_state_q, tx_state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [ZONE_W-1:0] shreg_q, shreg_d;
  logic              sclk_q, sclk_d, cs_n_q, cs_n_d, lat_q, lat_d;
  logic              busy_q, busy_d, done_q, done_d, rd_bank_q, rd_bank_d;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic [ZONE_W-1:0] rd_data_s;

  assign edge_s    = sflag_q & ~sflag_prev_q;
  assign tx_idle_s = (tx_state_q == T_IDLE) && !start_q;

  sdbp_zone_ram #(
    .NUM_ZONES(NUM_ZONES),
    .ZONE_W   (ZONE_W),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .we_i     (we_s),
    .wr_bank_i(wr_bank_q),
    .wr_idx_i (wtaddr - ADDR_W'(1)),
    .wr_data_i(wtdina),
    .rd_en_i  (rd_en_s),
    .rd_bank_i(rd_bank_d),
    .rd_idx_i (rd_idx_s),
    .rd_data_o(rd_data_s)
  );

  // Capture FSM: arm on sdbpflag edge, accept strictly ascending addresses.
  always_comb begin
    cap_state_d = cap_state_q;
    exp_addr_d  = exp_addr_q;
    wr_bank_d   = wr_bank_q;
    start_d     = 1'b0;
    err_d       = 1'b0;
    ovr_d       = 1'b0;
    we_s        = 1'b0;
    if (edge_s) begin
      // The edge wins over a same-cycle write; restarting a partial frame is an error.
      err_d       = (cap_state_q == C_FILL) && (exp_addr_q > ADDR_W'(1));
      cap_state_d = C_FILL;
      exp_addr_d  = ADDR_W'(1);
    end else if ((cap_state_q == C_FILL) && (wtaddr != {ADDR_W{1'b0}})) begin
      if (wtaddr == exp_addr_q) begin
        we_s       = 1'b1;
        exp_addr_d = exp_addr_q + ADDR_W'(1);
        if (wtaddr == ADDR_W'(NUM_ZONES)) begin
          cap_state_d = C_IDLE;
          if (tx_idle_s) begin
            wr_bank_d = ~wr_bank_q;
            start_d   = 1'b1;
          end else begin
            // Transmitter still busy: drop this frame, keep filling the same bank next time.
            ovr_d = 1'b1;
          end
        end else begin
          cap_state_d = C_FILL;
        end
      end else begin
        err_d       = 1'b1;
        cap_state_d = C_IDLE;
      end
    end else begin
      cap_state_d = cap_state_q;
    end
  end

  // Transmit FSM: load word 0, shift gaplessly with prefetch, deassert CS, latch.
  always_comb begin
    tx_state_d = tx_state_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    div_d      = div_q;
    shreg_d    = shreg_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    lat_d      = lat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_bank_d  = rd_bank_q;
    rd_en_s    = 1'b0;
    rd_idx_s   = idx_q;
    case (tx_state_q)
      T_IDLE: begin
        if (start_q) begin
          // wr_bank has already toggled, so the filled bank is its complement.
          tx_state_d = T_LOAD;
          busy_d     = 1'b1;
          rd_bank_d  = ~wr_bank_q;
          idx_d      = {ADDR_W{1'b0}};
          rd_en_s    = 1'b1;
          rd_idx_s   = {ADDR_W{1'b0}};
        end else begin
          busy_d = 1'b0;
        end
      end
      T_LOAD: begin
        shreg_d    = rd_data_s;
        cs_n_d     = 1'b0;
        div_d      = {CNT_W{1'b0}};
        bit_d      = BIT_W'(ZONE_W - 1);
        tx_state_d = T_SHIFT;
        rd_en_s    = 1'b1;
        rd_idx_s   = idx_q + ADDR_W'(1);
      end
      T_SHIFT: begin
        if (div_q == CNT_W'(CLK_DIV - 1)) begin
          div_d = {CNT_W{1'b0}};
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == {BIT_W{1'b0}}) begin
              if (idx_q == ADDR_W'(NUM_ZONES - 1)) begin
                tx_state_d = T_CSH;
                cs_n_d     = 1'b1;
                shreg_d    = {ZONE_W{1'b0}};
                idx_d      = {ADDR_W{1'b0}};
              end else begin
                // Prefetched word is already in rd_data; fetch the one after it.
                shreg_d  = rd_data_s;
                idx_d    = idx_q + ADDR_W'(1);
                bit_d    = BIT_W'(ZONE_W - 1);
                rd_en_s  = (idx_q + ADDR_W'(2)) < ADDR_W'(NUM_ZONES);
                rd_idx_s = idx_q + ADDR_W'(2);
              end
            end else begin
              shreg_d = shreg_q << 1;
              bit_d   = bit_q - BIT_W'(1);
            end
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      T_CSH: begin
        if (div_q == CNT_W'(CLK_DIV - 1)) begin
          div_d      = {CNT_W{1'b0}};
          lat_d      = 1'b1;
          tx_state_d = T_LATCH;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      T_LATCH: begin
        if (div_q == CNT_W'(LAT_CYCLES - 1)) begin
          div_d      = {CNT_W{1'b0}};
          lat_d      = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          tx_state_d = T_IDLE;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      default: begin
        tx_state_d = T_IDLE;
        sclk_d     = 1'b0;
        cs_n_d     = 1'b1;
        lat_d      = 1'b0;
        busy_d     = 1'b0;
        shreg_d    = {ZONE_W{1'b0}};
        div_d      = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; every output leaves a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sflag_q      <= 1'b0;
      sflag_prev_q <= 1'b0;
      cap_state_q  <= C_IDLE;
      exp_addr_q   <= ADDR_W'(1);
      wr_bank_q    <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
      ovr_q        <= 1'b0;
      tx_state_q   <= T_IDLE;
      idx_q        <= {ADDR_W{1'b0}};
      bit_q        <= {BIT_W{1'b0}};
      div_q        <= {CNT_W{1'b0}};
      shreg_q      <= {ZONE_W{1'b0}};
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      lat_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_bank_q    <= 1'b0;
    end else begin
      sflag_q      <= sdbpflag;
      sflag_prev_q <= sflag_q;
      cap_state_q  <= cap_state_d;
      exp_addr_q   <= exp_addr_d;
      wr_bank_q    <= wr_bank_d;
      start_q      <= start_d;
      err_q        <= err_d;
      ovr_q        <= ovr_d;
      tx_state_q   <= tx_state_d;
      idx_q        <= idx_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      shreg_q      <= shreg_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      lat_q        <= lat_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_bank_q    <= rd_bank_d;
    end
  end

  assign spi_sclk   = sclk_q;
  assign spi_mosi   = shreg_q[ZONE_W-1];
  assign spi_cs_n   = cs_n_q;
  assign spi_lat    = lat_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign frame_err  = err_q;

endmodule
